// File: rtl/dift_tag_check_sm_pkg.sv
// Shared types for the DIFT tag check unit: policy register, opclasses, trap types
// and the violation record carried by the trap register and the violation log.
package dift_tag_check_sm_pkg;

  localparam int DIFT_NUM_TRAP_TYPES = 5;

  typedef enum logic [1:0] {
    BRANCH_NONE,
    BRANCH_JAL,
    BRANCH_JALR,
    BRANCH_COND
  } dift_jump_t;

  typedef enum logic [1:0] {
    DIFT_BR_OFF,
    DIFT_BR_OR,
    DIFT_BR_AND,
    DIFT_BR_SINGL
  } dift_br_mode_t;

  typedef struct packed {
    logic          exec;
    logic          jalr;
    dift_br_mode_t branch;
    logic          branch_sel_b;  // SINGL mode: 1 checks op B, 0 checks op A
    logic          store;
    logic          load;
  } dift_tccr_t;

  typedef enum logic [2:0] {
    DIFT_OPCLASS_OTHER,
    DIFT_OPCLASS_LOAD,
    DIFT_OPCLASS_STORE,
    DIFT_OPCLASS_BRANCH,
    DIFT_OPCLASS_JUMP
  } dift_opclass_t;

  typedef enum logic [2:0] {
    DIFT_TRAP_TYPE_NONE,
    DIFT_TRAP_TYPE_EXEC,
    DIFT_TRAP_TYPE_JALR,
    DIFT_TRAP_TYPE_BRANCH,
    DIFT_TRAP_TYPE_STORE,
    DIFT_TRAP_TYPE_LOAD
  } dift_trap_t;

  typedef struct packed {
    dift_trap_t  trap_type;
    logic [31:0] pc;
  } dift_viol_rec_t;

  // Counter slot of a trap type: EXEC -> 0 ... LOAD -> 4; NONE maps out of range.
  function automatic logic [2:0] trap_idx(dift_trap_t t);
    return 3'(t) - 3'd1;
  endfunction

endpackage

// File: rtl/dift_tag_check_sm_viol_fifo.sv
// Violation log FIFO: DEPTH records, extra-MSB pointers for full/empty, sticky
// overflow when a push is dropped. A pop frees room for a same-cycle push.
module dift_viol_fifo
  import dift_tag_check_sm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  dift_viol_rec_t push_data_i,
  input  logic           pop_i,
  output dift_viol_rec_t head_o,
  output logic           full_o,
  output logic           empty_o,
  output logic           overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  dift_viol_rec_t mem_q [DEPTH];
  dift_viol_rec_t mem_d [DEPTH];
  logic           overflow_q, overflow_d;
  logic           do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wptr_q[AW-1:0]] = push_data_i;
    wptr_d     = wptr_q + PW'(do_push);
    rptr_d     = rptr_q + PW'(do_pop);
    overflow_d = overflow_q | (push_i & ~do_push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign head_o     = mem_q[rptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/dift_tag_check_sm.sv
// DIFT tag check unit: masked tag checks, per-type threshold counters, held trap
// with ack handshake. Optional violation log FIFO under `DIFT_TRAP_LOG_EN.
module dift_tag_check_sm
  import dift_tag_check_sm_pkg::*;
#(
  parameter int TAG_W     = 1,
  parameter int CNT_W     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  dift_tccr_t                         tccr_i,
  input  logic [TAG_W-1:0]                   tag_mask_i,
  input  logic [CNT_W-1:0]                   threshold_i,
  input  dift_opclass_t                      opclass_i,
  input  logic                               is_decoding_i,
  input  logic [1:0]                         jump_in_i,
  input  logic [31:0]                        pc_i,
  input  logic [TAG_W-1:0]                   instr_rtag_i,
  input  logic [TAG_W-1:0]                   jump_target_tag_i,
  input  logic [TAG_W-1:0]                   operand_a_tag_i,
  input  logic [TAG_W-1:0]                   operand_b_tag_i,
  output logic                               trap_o,
  output dift_trap_t                         trap_type_o,
  output logic [31:0]                        trap_pc_o,
  input  logic                               trap_ack_i,
  output logic                               trap_missed_o,
  input  logic                               cnt_clear_i,
  output logic [DIFT_NUM_TRAP_TYPES*CNT_W-1:0] cnt_o,
  output logic                               log_valid_o,
  output dift_trap_t                         log_type_o,
  output logic [31:0]                        log_pc_o,
  input  logic                               log_pop_i,
  output logic                               log_overflow_o
);

  typedef enum logic {TRAP_IDLE, TRAP_PENDING} trap_state_t;

  trap_state_t state_q, state_d;
  dift_viol_rec_t rec_q, rec_d;
  logic is_decoding_q, is_decoding_d;
  logic missed_q, missed_d;
  logic [DIFT_NUM_TRAP_TYPES-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic taint_instr, taint_jt, taint_a, taint_b;
  logic exec_hit, op_viol, viol, fire;
  dift_trap_t op_type, vtype;
  logic [2:0] vidx;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W:0] thr_eff;
  dift_viol_rec_t new_rec;

  assign is_decoding_d = is_decoding_i;
  assign taint_instr = |(instr_rtag_i & tag_mask_i);
  assign taint_jt    = |(jump_target_tag_i & tag_mask_i);
  assign taint_a     = |(operand_a_tag_i & tag_mask_i);
  assign taint_b     = |(operand_b_tag_i & tag_mask_i);

  always_comb begin
    op_viol = 1'b0;
    op_type = DIFT_TRAP_TYPE_NONE;
    case (opclass_i)
      DIFT_OPCLASS_LOAD: begin
        op_viol = tccr_i.load & taint_a;
        op_type = DIFT_TRAP_TYPE_LOAD;
      end
      DIFT_OPCLASS_STORE: begin
        op_viol = tccr_i.store & taint_a;
        op_type = DIFT_TRAP_TYPE_STORE;
      end
      DIFT_OPCLASS_BRANCH: begin
        op_type = DIFT_TRAP_TYPE_BRANCH;
        case (tccr_i.branch)
          DIFT_BR_OR:    op_viol = taint_a | taint_b;
          DIFT_BR_AND:   op_viol = taint_a & taint_b;
          DIFT_BR_SINGL: op_viol = tccr_i.branch_sel_b ? taint_b : taint_a;
          default:       op_viol = 1'b0;
        endcase
      end
      DIFT_OPCLASS_JUMP: begin
        op_viol = tccr_i.jalr & (jump_in_i == BRANCH_JALR) & taint_jt;
        op_type = DIFT_TRAP_TYPE_JALR;
      end
      default: begin
        op_viol = 1'b0;
        op_type = DIFT_TRAP_TYPE_NONE;
      end
    endcase
    exec_hit = tccr_i.exec & taint_instr;
    viol     = is_decoding_q & (exec_hit | op_viol);
    vtype    = exec_hit ? DIFT_TRAP_TYPE_EXEC : op_type;
    vidx     = trap_idx(vtype);
    new_rec  = '{trap_type: vtype, pc: pc_i};
  end

  // Threshold 0 behaves like 1; the +1 is done one bit wider so a saturated counter still fires.
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < DIFT_NUM_TRAP_TYPES; i++) begin
      if (vidx == 3'(i)) cur_cnt = cnt_q[i];
    end
    thr_eff = (threshold_i == '0) ? (CNT_W+1)'(1) : {1'b0, threshold_i};
    fire    = viol & (({1'b0, cur_cnt} + (CNT_W+1)'(1)) >= thr_eff);
    cnt_d   = cnt_q;
    for (int i = 0; i < DIFT_NUM_TRAP_TYPES; i++) begin
      if (cnt_clear_i) begin
        cnt_d[i] = '0;
      end else if (viol && (vidx == 3'(i))) begin
        if (fire) cnt_d[i] = '0;
        else if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    missed_d = missed_q;
    case (state_q)
      TRAP_IDLE: begin
        if (fire) begin
          state_d = TRAP_PENDING;
          rec_d   = new_rec;
        end
      end
      TRAP_PENDING: begin
        if (trap_ack_i && fire) begin
          rec_d = new_rec;
        end else if (trap_ack_i) begin
          state_d = TRAP_IDLE;
          rec_d   = '0;
        end else if (fire) begin
          missed_d = 1'b1;
        end
      end
      default: state_d = TRAP_IDLE;
    endcase
    if (cnt_clear_i) missed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TRAP_IDLE;
      rec_q         <= '0;
      missed_q      <= 1'b0;
      is_decoding_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rec_q         <= rec_d;
      missed_q      <= missed_d;
      is_decoding_q <= is_decoding_d;
      cnt_q         <= cnt_d;
    end
  end

  assign trap_o        = (state_q == TRAP_PENDING);
  assign trap_type_o   = rec_q.trap_type;
  assign trap_pc_o     = rec_q.pc;
  assign trap_missed_o = missed_q;
  assign cnt_o         = cnt_q;

`ifdef DIFT_TRAP_LOG_EN
  dift_viol_rec_t log_head;
  logic log_empty, unused_log_full;

  dift_viol_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (viol),
    .push_data_i(new_rec),
    .pop_i      (log_pop_i),
    .head_o     (log_head),
    .full_o     (unused_log_full),
    .empty_o    (log_empty),
    .overflow_o (log_overflow_o)
  );

  assign log_valid_o = ~log_empty;
  assign log_type_o  = log_empty ? DIFT_TRAP_TYPE_NONE : log_head.trap_type;
  assign log_pc_o    = log_empty ? 32'h0 : log_head.pc;
`else
  logic unused_log_pop;
  logic [$clog2(LOG_DEPTH):0] unused_log_ptr;
  assign unused_log_pop = log_pop_i;
  assign unused_log_ptr = '0;
  assign log_valid_o    = 1'b0;
  assign log_type_o     = DIFT_TRAP_TYPE_NONE;
  assign log_pc_o       = 32'h0;
  assign log_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_dift_tag_check_sm.sv
// Directed bench for dift_tag_check_sm: trap records and log entries go through
// expected queues checked by monitors; counters and sticky flags are checked inline.
module tb_dift_tag_check_sm;
  import dift_tag_check_sm_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 8;
  localparam int LOG_DEPTH = 4;
  localparam int CI_EXEC = 0, CI_JALR = 1, CI_BRAN = 2, CI_STORE = 3, CI_LOAD = 4;
`ifdef DIFT_TRAP_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  dift_tccr_t tccr_i;
  logic [TAG_W-1:0] tag_mask_i;
  logic [CNT_W-1:0] threshold_i;
  dift_opclass_t opclass_i;
  logic is_decoding_i;
  logic [1:0] jump_in_i;
  logic [31:0] pc_i;
  logic [TAG_W-1:0] instr_rtag_i, jump_target_tag_i, operand_a_tag_i, operand_b_tag_i;
  logic trap_o;
  dift_trap_t trap_type_o;
  logic [31:0] trap_pc_o;
  logic trap_ack_i;
  logic trap_missed_o;
  logic cnt_clear_i;
  logic [DIFT_NUM_TRAP_TYPES*CNT_W-1:0] cnt_o;
  logic log_valid_o;
  dift_trap_t log_type_o;
  logic [31:0] log_pc_o;
  logic log_pop_i;
  logic log_overflow_o;

  int n_checks = 0;
  int n_pass = 0;
  logic [34:0] exp_trap_q[$];
  logic [34:0] exp_log_q[$];

  dift_tag_check_sm #(.TAG_W(TAG_W), .CNT_W(CNT_W), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tccr_i(tccr_i), .tag_mask_i(tag_mask_i),
    .threshold_i(threshold_i), .opclass_i(opclass_i), .is_decoding_i(is_decoding_i),
    .jump_in_i(jump_in_i), .pc_i(pc_i), .instr_rtag_i(instr_rtag_i),
    .jump_target_tag_i(jump_target_tag_i), .operand_a_tag_i(operand_a_tag_i),
    .operand_b_tag_i(operand_b_tag_i), .trap_o(trap_o), .trap_type_o(trap_type_o),
    .trap_pc_o(trap_pc_o), .trap_ack_i(trap_ack_i), .trap_missed_o(trap_missed_o),
    .cnt_clear_i(cnt_clear_i), .cnt_o(cnt_o), .log_valid_o(log_valid_o),
    .log_type_o(log_type_o), .log_pc_o(log_pc_o), .log_pop_i(log_pop_i),
    .log_overflow_o(log_overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [CNT_W-1:0] get_cnt(input int k);
    return cnt_o[k*CNT_W +: CNT_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    opclass_i = DIFT_OPCLASS_OTHER;
    jump_in_i = BRANCH_NONE;
    instr_rtag_i = '0;
    jump_target_tag_i = '0;
    operand_a_tag_i = '0;
    operand_b_tag_i = '0;
    trap_ack_i = 1'b0;
    cnt_clear_i = 1'b0;
    log_pop_i = 1'b0;
  endtask

  task automatic exp_trap(input dift_trap_t t, input logic [31:0] pc);
    exp_trap_q.push_back({t, pc});
  endtask

  task automatic exp_log(input dift_trap_t t, input logic [31:0] pc);
    if (LOG_EN) exp_log_q.push_back({t, pc});
  endtask

  task automatic drain(input string name, input int exp_n);
    int n = 0;
    for (int i = 0; i < 2 * LOG_DEPTH; i++) begin
      if (log_valid_o) begin
        log_pop_i = 1'b1;
        step();
        n++;
      end
    end
    log_pop_i = 1'b0;
    check(name, n, exp_n);
  endtask

  // Trap monitor: a new record appears when trap_o rises or the held record changes.
  logic prev_trap = 1'b0;
  logic [34:0] prev_rec = '0;
  always @(negedge clk) begin
    logic [34:0] e;
    if (trap_o && (!prev_trap || {trap_type_o, trap_pc_o} != prev_rec)) begin
      if (exp_trap_q.size() == 0) begin
        n_checks++;
        $display("FAIL trap_unexpected: got %0h, required no new trap", {trap_type_o, trap_pc_o});
      end else begin
        e = exp_trap_q.pop_front();
        check("trap_record", {trap_type_o, trap_pc_o}, e);
      end
    end
    prev_trap = trap_o;
    prev_rec = {trap_type_o, trap_pc_o};
  end

  // Log monitor: every accepted pop is compared against the expected head.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst_n && log_pop_i && log_valid_o) begin
      if (exp_log_q.size() == 0) begin
        n_checks++;
        $display("FAIL log_unexpected: got %0h, required empty log", {log_type_o, log_pc_o});
      end else begin
        e = exp_log_q.pop_front();
        check("log_head", {log_type_o, log_pc_o}, e);
      end
    end
  end

  initial begin
    #100000;
    n_checks++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    tccr_i = '{exec: 1'b1, jalr: 1'b1, branch: DIFT_BR_OR, branch_sel_b: 1'b0,
               store: 1'b1, load: 1'b1};
    tag_mask_i = 4'hF;
    threshold_i = 8'd1;
    is_decoding_i = 1'b1;
    pc_i = 32'h0;
    #12;
    check("rst_trap_o", trap_o, 0);
    check("rst_trap_type", trap_type_o, DIFT_TRAP_TYPE_NONE);
    check("rst_trap_pc", trap_pc_o, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_missed", trap_missed_o, 0);
    check("rst_log_valid", log_valid_o, 0);
    check("rst_log_rec", {log_type_o, log_pc_o}, 0);
    check("rst_overflow", log_overflow_o, 0);
    step();
    rst_n = 1'b1;
    step();

    // Masked load check, then a load violation trapping one cycle later
    tag_mask_i = 4'b0100;
    opclass_i = DIFT_OPCLASS_LOAD;
    operand_a_tag_i = 4'b0010;
    pc_i = 32'h100;
    step();
    check("t1_masked_cnt_load", get_cnt(CI_LOAD), 0);
    check("t1_masked_trap_o", trap_o, 0);
    operand_a_tag_i = 4'b0110;
    pc_i = 32'h104;
    exp_trap(DIFT_TRAP_TYPE_LOAD, 32'h104);
    exp_log(DIFT_TRAP_TYPE_LOAD, 32'h104);
    step();
    set_idle();
    check("t1_trap_o", trap_o, 1);
    check("t1_trap_type", trap_type_o, DIFT_TRAP_TYPE_LOAD);
    check("t1_trap_pc", trap_pc_o, 32'h104);
    trap_ack_i = 1'b1;
    step();
    set_idle();
    check("t1_ack_trap_o", trap_o, 0);
    tag_mask_i = 4'hF;

    // Threshold 3: store violations trap on the third
    threshold_i = 8'd3;
    opclass_i = DIFT_OPCLASS_STORE;
    operand_a_tag_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'h200 + 32'(4 * i);
      if (i == 2) exp_trap(DIFT_TRAP_TYPE_STORE, 32'h208);
      exp_log(DIFT_TRAP_TYPE_STORE, pc_i);
      step();
      check("t2_cnt_store", get_cnt(CI_STORE), (i == 2) ? 0 : i + 1);
      check("t2_trap_o", trap_o, (i == 2) ? 1 : 0);
    end
    set_idle();
    check("t2_trap_pc", trap_pc_o, 32'h208);
    drain("t2_drain", LOG_EN ? 4 : 0);

    // Fire while pending: record held, missed set; then ack with same-cycle exec fire
    threshold_i = 8'd1;
    opclass_i = DIFT_OPCLASS_BRANCH;
    operand_b_tag_i = 4'b0001;
    pc_i = 32'h300;
    exp_log(DIFT_TRAP_TYPE_BRANCH, 32'h300);
    step();
    set_idle();
    check("t3_missed", trap_missed_o, 1);
    check("t3_held_rec", {trap_type_o, trap_pc_o}, {DIFT_TRAP_TYPE_STORE, 32'h208});
    check("t3_held_trap_o", trap_o, 1);
    trap_ack_i = 1'b1;
    instr_rtag_i = 4'b0001;
    pc_i = 32'h400;
    exp_trap(DIFT_TRAP_TYPE_EXEC, 32'h400);
    exp_log(DIFT_TRAP_TYPE_EXEC, 32'h400);
    step();
    set_idle();
    check("t3_reload_trap_o", trap_o, 1);
    check("t3_reload_rec", {trap_type_o, trap_pc_o}, {DIFT_TRAP_TYPE_EXEC, 32'h400});
    check("t3_missed_sticky", trap_missed_o, 1);
    trap_ack_i = 1'b1;
    step();
    set_idle();
    check("t3_idle_trap_o", trap_o, 0);

    // Exec has priority over the load check; clear overrides an increment
    threshold_i = 8'd5;
    opclass_i = DIFT_OPCLASS_LOAD;
    operand_a_tag_i = 4'b0001;
    instr_rtag_i = 4'b1000;
    pc_i = 32'h500;
    exp_log(DIFT_TRAP_TYPE_EXEC, 32'h500);
    step();
    set_idle();
    check("t4_cnt_exec", get_cnt(CI_EXEC), 1);
    check("t4_cnt_load", get_cnt(CI_LOAD), 0);
    cnt_clear_i = 1'b1;
    instr_rtag_i = 4'b0001;
    pc_i = 32'h504;
    exp_log(DIFT_TRAP_TYPE_EXEC, 32'h504);
    step();
    set_idle();
    check("t4_clear_cnt", cnt_o, 0);
    check("t4_clear_missed", trap_missed_o, 0);
    drain("t4_drain", LOG_EN ? 4 : 0);

    // Not decoding: fully tainted inputs are ignored
    is_decoding_i = 1'b0;
    step();
    opclass_i = DIFT_OPCLASS_LOAD;
    instr_rtag_i = 4'hF;
    operand_a_tag_i = 4'hF;
    operand_b_tag_i = 4'hF;
    jump_target_tag_i = 4'hF;
    pc_i = 32'h600;
    step();
    set_idle();
    check("t5_cnt", cnt_o, 0);
    check("t5_trap_o", trap_o, 0);
    check("t5_log_valid", log_valid_o, 0);
    is_decoding_i = 1'b1;
    step();

    // Log overflow, push+pop when full, drain, pop when empty
    threshold_i = 8'd255;
    opclass_i = DIFT_OPCLASS_LOAD;
    operand_a_tag_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      pc_i = 32'h700 + 32'(4 * i);
      if (i < 4) exp_log(DIFT_TRAP_TYPE_LOAD, pc_i);
      step();
    end
    check("t6_cnt_load", get_cnt(CI_LOAD), 5);
    check("t6_overflow", log_overflow_o, LOG_EN);
    check("t6_log_valid", log_valid_o, LOG_EN);
    log_pop_i = 1'b1;
    pc_i = 32'h714;
    exp_log(DIFT_TRAP_TYPE_LOAD, 32'h714);
    step();
    set_idle();
    check("t6_cnt_load_6", get_cnt(CI_LOAD), 6);
    drain("t6_drain", LOG_EN ? 4 : 0);
    log_pop_i = 1'b1;
    step();
    set_idle();
    check("t6_empty_valid", log_valid_o, 0);
    check("t6_empty_rec", {log_type_o, log_pc_o}, 0);
    check("t6_overflow_sticky", log_overflow_o, LOG_EN);
    cnt_clear_i = 1'b1;
    step();
    set_idle();

    // JALR only for BRANCH_JALR; branch AND and SINGL(op B) modes
    threshold_i = 8'd1;
    opclass_i = DIFT_OPCLASS_JUMP;
    jump_in_i = BRANCH_JAL;
    jump_target_tag_i = 4'b0001;
    pc_i = 32'h800;
    step();
    check("t7_jal_trap_o", trap_o, 0);
    check("t7_jal_cnt", get_cnt(CI_JALR), 0);
    jump_in_i = BRANCH_JALR;
    pc_i = 32'h804;
    exp_trap(DIFT_TRAP_TYPE_JALR, 32'h804);
    exp_log(DIFT_TRAP_TYPE_JALR, 32'h804);
    step();
    set_idle();
    check("t7_jalr_type", trap_type_o, DIFT_TRAP_TYPE_JALR);
    trap_ack_i = 1'b1;
    step();
    set_idle();
    tccr_i.branch = DIFT_BR_AND;
    opclass_i = DIFT_OPCLASS_BRANCH;
    operand_a_tag_i = 4'b0001;
    pc_i = 32'h808;
    step();
    check("t7_and_trap_o", trap_o, 0);
    tccr_i.branch = DIFT_BR_SINGL;
    tccr_i.branch_sel_b = 1'b1;
    pc_i = 32'h80c;
    step();
    check("t7_singl_a_trap_o", trap_o, 0);
    operand_a_tag_i = 4'b0000;
    operand_b_tag_i = 4'b0001;
    pc_i = 32'h810;
    exp_trap(DIFT_TRAP_TYPE_BRANCH, 32'h810);
    exp_log(DIFT_TRAP_TYPE_BRANCH, 32'h810);
    step();
    set_idle();
    check("t7_singl_b_type", trap_type_o, DIFT_TRAP_TYPE_BRANCH);
    check("t7_cnt_bran", get_cnt(CI_BRAN), 0);
    trap_ack_i = 1'b1;
    step();
    set_idle();
    drain("t7_drain", LOG_EN ? 2 : 0);

    // Reset while a trap is pending drops the trap and the log
    instr_rtag_i = 4'b0001;
    pc_i = 32'h900;
    exp_trap(DIFT_TRAP_TYPE_EXEC, 32'h900);
    step();
    set_idle();
    #6;
    rst_n = 1'b0;
    #1;
    check("t8_rst_trap_o", trap_o, 0);
    check("t8_rst_rec", {trap_type_o, trap_pc_o}, 0);
    check("t8_rst_log_valid", log_valid_o, 0);
    check("t8_rst_overflow", log_overflow_o, 0);
    check("t8_rst_cnt_store", get_cnt(CI_STORE), 0);
    #1;
    rst_n = 1'b1;
    step();
    step();

    check("trap_queue_empty", exp_trap_q.size(), 0);
    check("log_queue_empty", exp_log_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
